// File: rtl/har_arbiter.sv
// har_arbiter: round-robin front end that lets two requesters share one
// combinational classifier core. One request is outstanding at a time. The
// accepted feature vector is registered onto core_inp. It is held there while
// the core settles for LAT cycles. The class result is then captured and
// offered on a valid/ready response port.

module har_arbiter #(
  parameter int N   = 12,
  parameter int B   = 4,
  parameter int C   = 6,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [N*B-1:0]       req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [N*B-1:0]       req1_data,
  output logic                 req1_ready,
  output logic [N*B-1:0]       core_inp,
  input  logic [$clog2(C)-1:0] core_klass,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [$clog2(C)-1:0] rsp_klass,
  output logic                 rsp_err
);

  localparam int KW = $clog2(C);
  localparam int W  = N * B;
  localparam int CW = $clog2(LAT + 1);

  // Counter value seen on the edge where the core has settled for LAT cycles.
  localparam logic [CW-1:0] LastCount  = CW'(LAT - 1);
  // One extra bit so that a power-of-two C still compares correctly.
  localparam logic [KW:0]   ClassLimit = (KW + 1)'(C);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            lastGnt_q, lastGnt_d;
  logic [W-1:0]    coreInp_q, coreInp_d;
  logic            rspId_q, rspId_d;
  logic [KW-1:0]   rspKlass_q, rspKlass_d;
  logic            rspErr_q, rspErr_d;

  logic            isIdle;
  logic            pick1;
  logic            accept;
  logic            klassOutOfRange;

  assign isIdle          = (state_q == IDLE);
  assign klassOutOfRange = ({1'b0, core_klass} >= ClassLimit);

  // Choose requester 1 when it asks alone, or on a tie when requester 0 won last.
  always_comb begin
    pick1 = req1_valid;
    if (req0_valid && req1_valid) begin
      pick1 = ~lastGnt_q;
    end
  end

  assign req0_ready = isIdle && req0_valid && !pick1;
  assign req1_ready = isIdle && req1_valid && pick1;
  assign accept     = req0_ready || req1_ready;

  assign core_inp  = coreInp_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rspId_q;
  assign rsp_klass = rspKlass_q;
  assign rsp_err   = rspErr_q;

  // Next-state and datapath updates for the IDLE -> WAIT -> RESP transaction.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lastGnt_d  = lastGnt_q;
    coreInp_d  = coreInp_q;
    rspId_d    = rspId_q;
    rspKlass_d = rspKlass_q;
    rspErr_d   = rspErr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          coreInp_d = pick1 ? req1_data : req0_data;
          rspId_d   = pick1;
          lastGnt_d = pick1;
          count_d   = '0;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        count_d = count_q + CW'(1);
        if (count_q == LastCount) begin
          rspKlass_d = core_klass;
          rspErr_d   = klassOutOfRange;
          state_d    = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      lastGnt_q  <= 1'b1;
      coreInp_q  <= '0;
      rspId_q    <= 1'b0;
      rspKlass_q <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lastGnt_q  <= lastGnt_d;
      coreInp_q  <= coreInp_d;
      rspId_q    <= rspId_d;
      rspKlass_q <= rspKlass_d;
      rspErr_q   <= rspErr_d;
    end
  end

endmodule

// File: tb/tb_har_arbiter.sv
// tb_har_arbiter: directed scenarios followed by randomized traffic. A
// transaction-level model of the arbiter is checked every cycle.

module tb_har_arbiter;

  localparam int N   = 12;
  localparam int B   = 4;
  localparam int C   = 6;
  localparam int LAT = 2;
  localparam int KW  = $clog2(C);
  localparam int W   = N * B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0_valid = 1'b0;
  logic [W-1:0]  req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [W-1:0]  req1_data = '0;
  logic          req1_ready;
  logic [W-1:0]  core_inp;
  logic [KW-1:0] core_klass;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_id;
  logic [KW-1:0] rsp_klass;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic          ovEn = 1'b1;
  logic [KW-1:0] ovVal = '0;

  har_arbiter #(.N(N), .B(B), .C(C), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .core_inp   (core_inp),
    .core_klass (core_klass),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_klass  (rsp_klass),
    .rsp_err    (rsp_err)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Stand-in classifier: XOR-fold of the feature vector, or a forced value.
  function automatic logic [KW-1:0] coreFn(input logic [W-1:0] d);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i + KW <= W; i += KW) r ^= d[i +: KW];
    return r;
  endfunction

  assign core_klass = ovEn ? ovVal : coreFn(core_inp);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference model: busy flag, settle countdown, captured result.
  bit            mBusy = 1'b0;
  int            mWait = 0;
  bit            mLast = 1'b1;
  logic [W-1:0]  mCore = '0;
  bit            mId = 1'b0;
  logic [KW-1:0] mKlass = '0;
  bit            mErr = 1'b0;

  // Compare the DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    bit expValid, g0, g1;
    if (!rst_n) begin
      mBusy = 1'b0; mWait = 0; mLast = 1'b1; mCore = '0;
      mId = 1'b0; mKlass = '0; mErr = 1'b0;
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      checkOutput("rst_core_inp", 64'(core_inp), 64'(0));
      checkOutput("rst_rsp_id", 64'(rsp_id), 64'(0));
      checkOutput("rst_rsp_klass", 64'(rsp_klass), 64'(0));
      checkOutput("rst_rsp_err", 64'(rsp_err), 64'(0));
    end else begin
      expValid = mBusy && (mWait == 0);
      g0 = !mBusy && req0_valid && (!req1_valid || mLast);
      g1 = !mBusy && req1_valid && (!req0_valid || !mLast);
      checkOutput("m_req0_ready", 64'(req0_ready), 64'(g0));
      checkOutput("m_req1_ready", 64'(req1_ready), 64'(g1));
      checkOutput("m_rsp_valid", 64'(rsp_valid), 64'(expValid));
      checkOutput("m_core_inp", 64'(core_inp), 64'(mCore));
      if (expValid) begin
        checkOutput("m_rsp_id", 64'(rsp_id), 64'(mId));
        checkOutput("m_rsp_klass", 64'(rsp_klass), 64'(mKlass));
        checkOutput("m_rsp_err", 64'(rsp_err), 64'(mErr));
      end
      if (expValid) begin
        if (rsp_ready) mBusy = 1'b0;
      end else if (mBusy) begin
        mWait--;
        if (mWait == 0) begin
          mKlass = ovEn ? ovVal : coreFn(mCore);
          mErr   = (int'(mKlass) >= C);
        end
      end else if (g0 || g1) begin
        mBusy = 1'b1;
        mWait = LAT;
        mCore = g0 ? req0_data : req1_data;
        mId   = g1;
        mLast = g1;
      end
    end
  end

  task automatic waitRsp(output int n);
    bit ok;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) checkOutput("rsp_timeout", 64'(rsp_valid), 64'(1));
  endtask

  task automatic finishRsp();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic doReset(input int cycles);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle of random requester/consumer behaviour with rare reset pulses.
  task automatic applyStimulus();
    bit f0, f1;
    @(negedge clk);
    f0 = req0_valid && req0_ready;
    f1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    if (!rst_n) rst_n = 1'b1;
    else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
    if (f0 || (req0_valid && $urandom_range(0, 19) == 0)) req0_valid = 1'b0;
    else if (!req0_valid && $urandom_range(0, 9) < 4) begin
      req0_valid = 1'b1;
      req0_data  = W'({$urandom(), $urandom()});
    end
    if (f1 || (req1_valid && $urandom_range(0, 19) == 0)) req1_valid = 1'b0;
    else if (!req1_valid && $urandom_range(0, 9) < 4) begin
      req1_valid = 1'b1;
      req1_data  = W'({$urandom(), $urandom()});
    end
    rsp_ready = ($urandom_range(0, 9) < 6);
  endtask

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    int n, prev;
    logic [W-1:0] dA, dB0, dB1, dC;
    dA  = 48'hb9811498a121;
    dB0 = 48'hb9700187a110;
    dB1 = 48'hb9700088a000;
    dC  = 48'h123456789abc;
    prev = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request with a forced class of 3.
    ovEn = 1'b1; ovVal = 3'd3;
    req0_data = dA; req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("A_req0_ready", 64'(req0_ready), 64'(1));
    checkOutput("A_req1_ready", 64'(req1_ready), 64'(0));
    @(posedge clk); #1 req0_valid = 1'b0;
    waitRsp(n);
    checkOutput("A_latency", 64'(n), 64'(2));
    checkOutput("A_core_inp", 64'(core_inp), 64'(48'hb9811498a121));
    checkOutput("A_rsp_id", 64'(rsp_id), 64'(0));
    checkOutput("A_rsp_klass", 64'(rsp_klass), 64'(3));
    checkOutput("A_rsp_err", 64'(rsp_err), 64'(0));
    finishRsp();

    // Tie straight after reset: requester 0 first, then requester 1.
    doReset(1);
    ovEn = 1'b0;
    req0_data = dB0; req1_data = dB1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("B_req0_ready", 64'(req0_ready), 64'(1));
    checkOutput("B_req1_ready", 64'(req1_ready), 64'(0));
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("B_core_inp0", 64'(core_inp), 64'(48'hb9700187a110));
    waitRsp(n);
    checkOutput("B_rsp_id0", 64'(rsp_id), 64'(0));
    finishRsp();
    @(negedge clk);
    checkOutput("B_req1_ready", 64'(req1_ready), 64'(1));
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    checkOutput("B_core_inp1", 64'(core_inp), 64'(48'hb9700088a000));
    waitRsp(n);
    checkOutput("B_rsp_id1", 64'(rsp_id), 64'(1));
    finishRsp();

    // Back-pressure: response held for 5 cycles while requester 1 waits.
    req0_data = dC; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    req1_data = dB1; req1_valid = 1'b1;
    waitRsp(n);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("C_rsp_valid", 64'(rsp_valid), 64'(1));
      checkOutput("C_rsp_klass", 64'(rsp_klass), 64'(coreFn(dC)));
      checkOutput("C_req1_ready", 64'(req1_ready), 64'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("C_idle_valid", 64'(rsp_valid), 64'(0));
    checkOutput("C_req1_granted", 64'(req1_ready), 64'(1));
    @(posedge clk); #1 req1_valid = 1'b0;
    waitRsp(n);
    finishRsp();

    // Continuous contention with the consumer always ready.
    req0_data = dA; req1_data = dB0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      waitRsp(n);
      checkOutput("D_rsp_id", 64'(rsp_id), 64'(k % 2));
      if (k > 0) checkOutput("D_period", 64'(cyc - prev), 64'(LAT + 2));
      prev = cyc;
      @(posedge clk);
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    // Out-of-range class from the core.
    ovEn = 1'b1; ovVal = 3'd7;
    req0_data = dB1; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    waitRsp(n);
    checkOutput("E_rsp_klass", 64'(rsp_klass), 64'(7));
    checkOutput("E_rsp_err", 64'(rsp_err), 64'(1));
    checkOutput("E_rsp_id", 64'(rsp_id), 64'(0));
    finishRsp();
    ovEn = 1'b0;

    // Reset one cycle after accept abandons the transaction.
    req0_data = dC; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("F_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("F_core_inp", 64'(core_inp), 64'(0));
    checkOutput("F_rsp_klass", 64'(rsp_klass), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      checkOutput("F_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("F_req0_ready", 64'(req0_ready), 64'(1));
    checkOutput("F_req1_ready", 64'(req1_ready), 64'(0));
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    waitRsp(n);
    finishRsp();

    // Randomized traffic checked by the model.
    for (int t = 0; t < 3000; t++) applyStimulus();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1; rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
